// File: rtl/hdmi_8pix_pack.sv
// hdmi_8pix_pack: packs a stream of 8-bit intensity pixels into 64-bit
// framebuffer words (pixel 0 in byte 0) and writes them to memory through a
// req/ack port. Start-of-frame resynchronises the word address to the frame
// base, flushing any partially filled word first.
module hdmi_8pix_pack #(
    parameter logic [18:0] ADDR_BASE   = 19'd0,
    parameter logic [18:0] FRAME_WORDS = 19'd38400
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [7:0]  pix_data,
    input  logic        pix_sof,
    output logic        wr_en,
    output logic [18:0] wr_addr,
    output logic [63:0] wr_data,
    output logic [7:0]  wr_be,
    input  logic        wr_ack,
    output logic        frame_wrap,
    output logic        err_short
);

    localparam logic [18:0] ADDR_LAST = ADDR_BASE + FRAME_WORDS - 19'd1;

    // Pixel-side state
    logic [2:0]  r_count;
    logic [55:0] r_acc;
    logic [18:0] r_nxt;
    logic        r_err_short;

    // Write-port state
    logic        r_wr_en;
    logic [18:0] r_wr_addr;
    logic [63:0] r_wr_data;
    logic [7:0]  r_wr_be;
    logic        r_wr_last;
    logic        r_frame_wrap;

    logic        w_slot_free;
    logic        w_ready;
    logic        w_accept;
    logic        w_full;
    logic        w_flush;
    logic        w_load;
    logic [18:0] w_nxt_inc;
    logic [63:0] w_flush_data;
    logic [7:0]  w_flush_be;

    // The output slot can take a new word if it is empty or being acked now.
    assign w_slot_free = !r_wr_en || wr_ack;

    // A pixel only has to wait for the slot when it would emit a word:
    // the 8th byte of a word, or an sof that must flush a partial word.
    assign w_ready  = !reset && ((r_count == 3'd0) || w_slot_free ||
                                 ((r_count != 3'd7) && !pix_sof));
    assign w_accept = pix_valid && w_ready;
    assign w_full   = w_accept && !pix_sof && (r_count == 3'd7);
    assign w_flush  = w_accept && pix_sof && (r_count != 3'd0);
    assign w_load   = w_full || w_flush;

    assign w_nxt_inc = (r_nxt == ADDR_LAST) ? ADDR_BASE : (r_nxt + 19'd1);

    // Partial-word image: only the lanes already filled are kept and enabled.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_flush_lane
            assign w_flush_data[gi*8 +: 8] = (3'(gi) < r_count) ? r_acc[gi*8 +: 8] : 8'h00;
            assign w_flush_be[gi]          = (3'(gi) < r_count);
        end
    endgenerate
    assign w_flush_data[63:56] = 8'h00;
    assign w_flush_be[7]       = 1'b0;

    // Accumulate accepted pixels, track the next word address, flag short frames.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count     <= 3'd0;
            r_acc       <= 56'd0;
            r_nxt       <= ADDR_BASE;
            r_err_short <= 1'b0;
        end else begin
            r_err_short <= 1'b0;
            if (w_accept) begin
                if (pix_sof) begin
                    // Mid-frame sof: either a partial word or an unaligned address.
                    r_err_short <= (r_count != 3'd0) || (r_nxt != ADDR_BASE);
                    r_nxt       <= ADDR_BASE;
                    r_acc       <= {48'd0, pix_data};
                    r_count     <= 3'd1;
                end else if (r_count == 3'd7) begin
                    r_nxt   <= w_nxt_inc;
                    r_acc   <= 56'd0;
                    r_count <= 3'd0;
                end else begin
                    for (int i = 0; i < 7; i++) begin
                        if (r_count == 3'(i)) begin
                            r_acc[i*8 +: 8] <= pix_data;
                        end
                    end
                    r_count <= r_count + 3'd1;
                end
            end
        end
    end

    // Output slot: load a new word when one is emitted, otherwise retire on ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= ADDR_BASE;
            r_wr_data <= 64'd0;
            r_wr_be   <= 8'h00;
            r_wr_last <= 1'b0;
        end else if (w_load) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_nxt;
            if (w_full) begin
                r_wr_data <= {pix_data, r_acc};
                r_wr_be   <= 8'hFF;
                r_wr_last <= (r_nxt == ADDR_LAST);
            end else begin
                r_wr_data <= w_flush_data;
                r_wr_be   <= w_flush_be;
                r_wr_last <= 1'b0;
            end
        end else if (r_wr_en && wr_ack) begin
            r_wr_en <= 1'b0;
        end
    end

    // Pulse once when the final full word of a frame has been accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_frame_wrap <= 1'b0;
        end else begin
            r_frame_wrap <= r_wr_en && wr_ack && r_wr_last;
        end
    end

    assign pix_ready  = w_ready;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign wr_be      = r_wr_be;
    assign frame_wrap = r_frame_wrap;
    assign err_short  = r_err_short;

endmodule

// File: tb/tb_hdmi_8pix_pack.sv
// Directed bench for hdmi_8pix_pack with a 64-word frame.
module tb_hdmi_8pix_pack;

    localparam logic [18:0] FW = 19'd64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic [7:0]  pix_data = 8'h00;
    logic        wr_ack = 1'b0;
    logic        pix_ready;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_be;
    logic        frame_wrap;
    logic        err_short;

    int checks = 0;
    int errors = 0;

    logic [18:0] q_addr[$];
    logic [63:0] q_data[$];
    logic [7:0]  q_be[$];
    logic [63:0] exp_w[$];
    int  en_cycles = 0;
    int  fw_cnt = 0;
    int  fw_bad = 0;
    int  err_cnt = 0;
    bit  prev_last = 1'b0;
    bit  ack_rand = 1'b0;

    hdmi_8pix_pack #(
        .ADDR_BASE   (19'd0),
        .FRAME_WORDS (FW)
    ) u_dut (
        .clock      (clk),
        .reset      (rst),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .wr_ack     (wr_ack),
        .frame_wrap (frame_wrap),
        .err_short  (err_short)
    );

    always #5 clk = ~clk;

    // Record every completed write and count status pulses, mid-cycle.
    initial forever begin
        @(negedge clk);
        if (wr_en && wr_ack) begin
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
            q_be.push_back(wr_be);
        end
        if (wr_en) en_cycles++;
        if (frame_wrap) begin
            fw_cnt++;
            if (!prev_last) fw_bad++;
        end
        prev_last = wr_en && wr_ack && (wr_addr == FW - 19'd1);
        if (err_short) err_cnt++;
    end

    // Random acknowledge generator for the soak phase.
    initial forever begin
        @(posedge clk);
        #1;
        if (ack_rand) wr_ack = 1'($urandom_range(0, 1));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        q_addr.delete();
        q_data.delete();
        q_be.delete();
        en_cycles = 0;
        fw_cnt = 0;
        fw_bad = 0;
        err_cnt = 0;
        prev_last = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic ack);
        ack_rand = 1'b0;
        rst = 1'b1;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        wr_ack = ack;
        wait_cycles(2);
        rst = 1'b0;
        clear_mon();
    endtask

    // Offer one pixel and hold it until accepted (bounded).
    task automatic send(input logic [7:0] d, input logic s);
        int w;
        pix_valid = 1'b1;
        pix_data = d;
        pix_sof = s;
        w = 0;
        @(negedge clk);
        while (!pix_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("send_ready", 64'(pix_ready), 64'd1);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
    endtask

    task automatic check_word(input int idx, input logic [18:0] a, input logic [63:0] d,
                              input logic [7:0] be);
        if (idx < q_addr.size()) begin
            chk($sformatf("w%0d_addr", idx), 64'(q_addr[idx]), 64'(a));
            chk($sformatf("w%0d_data", idx), q_data[idx], d);
            chk($sformatf("w%0d_be", idx), 64'(q_be[idx]), 64'(be));
        end else begin
            chk($sformatf("w%0d_present", idx), 64'(q_addr.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        logic [63:0] cur;
        logic [7:0]  d;
        int          bad;

        // ---- Reset state (asynchronous, before any clock edge) ----
        #2;
        rst = 1'b1;
        #1;
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", wr_data, 64'd0);
        chk("rst_wr_be", 64'(wr_be), 64'd0);
        chk("rst_ready", 64'(pix_ready), 64'd0);
        chk("rst_frame_wrap", 64'(frame_wrap), 64'd0);
        chk("rst_err_short", 64'(err_short), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();

        // ---- Test 1: one word, ack tied high ----
        wr_ack = 1'b1;
        for (int k = 0; k < 8; k++) send(8'(k), k == 0);
        chk("t1_wr_en_now", 64'(wr_en), 64'd1);
        chk("t1_addr", 64'(wr_addr), 64'd0);
        chk("t1_data", wr_data, 64'h0706050403020100);
        chk("t1_be", 64'(wr_be), 64'hFF);
        wait_cycles(1);
        chk("t1_wr_en_drop", 64'(wr_en), 64'd0);
        wait_cycles(2);
        chk("t1_en_cycles", 64'(en_cycles), 64'd1);
        chk("t1_nwords", 64'(q_addr.size()), 64'd1);
        check_word(0, 19'd0, 64'h0706050403020100, 8'hFF);

        // ---- Test 2: back-pressure while the slot is stalled ----
        do_reset(1'b0);
        for (int k = 0; k < 15; k++) send(8'(k), k == 0);
        pix_valid = 1'b1;
        pix_data = 8'h0F;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t2_stall_ready", 64'(pix_ready), 64'd0);
            chk("t2_stall_data", wr_data, 64'h0706050403020100);
            chk("t2_stall_en", 64'(wr_en), 64'd1);
            @(posedge clk);
            #1;
        end
        wr_ack = 1'b1;
        @(negedge clk);
        chk("t2_ready_on_ack", 64'(pix_ready), 64'd1);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        chk("t2_b2b_en", 64'(wr_en), 64'd1);
        chk("t2_b2b_addr", 64'(wr_addr), 64'd1);
        chk("t2_b2b_data", wr_data, 64'h0F0E0D0C0B0A0908);
        wait_cycles(2);
        chk("t2_nwords", 64'(q_addr.size()), 64'd2);
        check_word(0, 19'd0, 64'h0706050403020100, 8'hFF);
        check_word(1, 19'd1, 64'h0F0E0D0C0B0A0908, 8'hFF);

        // ---- Test 3: full frame then wrap ----
        do_reset(1'b1);
        for (int k = 0; k < 520; k++) send(8'(k), k == 0);
        wait_cycles(3);
        chk("t3_nwords", 64'(q_addr.size()), 64'd65);
        bad = 0;
        for (int i = 0; i < 64 && i < q_addr.size(); i++)
            if (q_addr[i] !== 19'(i)) bad++;
        chk("t3_addr_seq_bad", 64'(bad), 64'd0);
        check_word(63, 19'd63, 64'hFFFEFDFCFBFAF9F8, 8'hFF);
        check_word(64, 19'd0, 64'h0706050403020100, 8'hFF);
        chk("t3_fw_cnt", 64'(fw_cnt), 64'd1);
        chk("t3_fw_timing_bad", 64'(fw_bad), 64'd0);
        chk("t3_err_cnt", 64'(err_cnt), 64'd0);

        // ---- Test 4: short word flushed by sof ----
        do_reset(1'b1);
        for (int k = 0; k < 40; k++) send(8'(k), k == 0);
        send(8'hA0, 1'b0);
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'h55, 1'b1);
        chk("t4_err_pulse", 64'(err_short), 64'd1);
        chk("t4_flush_addr", 64'(wr_addr), 64'd5);
        for (int k = 0; k < 7; k++) send(8'h56 + 8'(k), 1'b0);
        wait_cycles(2);
        chk("t4_nwords", 64'(q_addr.size()), 64'd7);
        check_word(5, 19'd5, 64'h0000000000A2A1A0, 8'h07);
        check_word(6, 19'd0, 64'h5C5B5A5958575655, 8'hFF);
        chk("t4_err_cnt", 64'(err_cnt), 64'd1);
        // sof on a word boundary but away from the frame base: error, no write
        send(8'h77, 1'b1);
        chk("t4b_err_pulse", 64'(err_short), 64'd1);
        wait_cycles(2);
        chk("t4b_nwords", 64'(q_addr.size()), 64'd7);
        chk("t4b_err_cnt", 64'(err_cnt), 64'd2);

        // ---- Test 5: asynchronous reset during a stall ----
        do_reset(1'b0);
        for (int k = 0; k < 8; k++) send(8'(k), k == 0);
        for (int k = 0; k < 4; k++) send(8'h10 + 8'(k), 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_wr_en", 64'(wr_en), 64'd0);
        chk("t5_addr", 64'(wr_addr), 64'd0);
        chk("t5_data", wr_data, 64'd0);
        chk("t5_be", 64'(wr_be), 64'd0);
        chk("t5_ready", 64'(pix_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
        wr_ack = 1'b1;
        for (int k = 0; k < 8; k++) send(8'h30 + 8'(k), k == 0);
        wait_cycles(2);
        chk("t5_nwords", 64'(q_addr.size()), 64'd1);
        check_word(0, 19'd0, 64'h3736353433323130, 8'hFF);
        chk("t5_err_cnt", 64'(err_cnt), 64'd0);

        // ---- Test 6: random gaps on both sides over three frames ----
        do_reset(1'b0);
        exp_w.delete();
        ack_rand = 1'b1;
        cur = 64'd0;
        for (int p = 0; p < 3 * 512; p++) begin
            wait_cycles($urandom_range(0, 2));
            d = 8'($urandom);
            send(d, (p % 512) == 0);
            cur = {d, cur[63:8]};
            if ((p % 8) == 7) exp_w.push_back(cur);
        end
        for (int c = 0; c < 400 && q_addr.size() < 192; c++) wait_cycles(1);
        wait_cycles(3);
        chk("t6_nwords", 64'(q_addr.size()), 64'd192);
        for (int i = 0; i < 192 && i < q_addr.size(); i++) begin
            chk($sformatf("t6_w%0d_addr", i), 64'(q_addr[i]), 64'(i % 64));
            chk($sformatf("t6_w%0d_data", i), q_data[i], exp_w[i]);
        end
        bad = 0;
        for (int i = 0; i < q_be.size(); i++)
            if (q_be[i] !== 8'hFF) bad++;
        chk("t6_be_bad", 64'(bad), 64'd0);
        chk("t6_fw_cnt", 64'(fw_cnt), 64'd3);
        chk("t6_fw_timing_bad", 64'(fw_bad), 64'd0);
        chk("t6_err_cnt", 64'(err_cnt), 64'd0);
        ack_rand = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdmi_8pix_pack.md
Name: hdmi_8pix_pack

Overview:
- Write-side counterpart of the 8-pixel framebuffer reader.
- Accepts a stream of 8-bit intensity pixels and packs eight consecutive pixels into one 64-bit framebuffer word.
- Pixel 0 goes in bits [7:0] and pixel 7 in bits [63:56], matching the reader's x[2:0] byte select.
- Writes each word to framebuffer memory at a 19-bit word address using a req/ack handshake, and resynchronises the address on start-of-frame.

Parameters:
- ADDR_BASE, 19'd0, word address of pixel (0,0).
- FRAME_WORDS, 19'd38400, words per frame (640x480/8); the address wraps after ADDR_BASE+FRAME_WORDS-1.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- pix_valid  input  1  pixel offered
- pix_ready  output  1  pixel accepted when pix_valid && pix_ready
- pix_data  input  8  intensity
- pix_sof  input  1  qualifies the first pixel of a frame
- wr_en  output  1  write request, held until acknowledged
- wr_addr  output  19  word address
- wr_data  output  64  packed pixels
- wr_be  output  8  byte enables; bit i covers wr_data[8i+7:8i]
- wr_ack  input  1  memory accepted the write this cycle
- frame_wrap  output  1  one-cycle pulse when the last word of a frame is acked
- err_short  output  1  one-cycle pulse when sof arrives mid-frame

Behaviour:
- Reset (async, active-high) clears all state and outputs:
  - wr_en=0, wr_addr=ADDR_BASE, wr_data=0, wr_be=0
  - frame_wrap=0, err_short=0
  - internal count=0, next-address register=ADDR_BASE, accumulator cleared
- Reset mid-write drops the pending word; no ack is expected afterwards.
- Definitions:
  - slot_free = !wr_en || wr_ack.
  - count (0..7) = bytes held in the accumulator.
  - nxt = address the next emitted word will use.
- pix_ready is combinational: (count==0) || slot_free || (count<7 && !pix_sof). It is 0 while reset is high.
- Accepted pixel, no sof:
  - The byte is stored at lane count, and count increments.
  - On the 8th byte (count==7), acc plus the byte are loaded into wr_data, wr_be=8'hFF, wr_addr=nxt, and wr_en=1 on the next edge.
  - Then count=0 and nxt advances.
- Latency: 8th pixel accepted at edge N gives wr_en high from edge N+1.
- Accepted pixel with pix_sof:
  - If count!=0, the partial word is flushed: wr_data=acc with unused lanes 0, wr_be has the low count bits set, wr_addr=nxt, and err_short pulses.
  - If count==0 and nxt!=ADDR_BASE, err_short pulses and nothing is written.
  - In both cases nxt=ADDR_BASE, the sof pixel goes to lane 0, and count=1.
  - If count==0 and nxt==ADDR_BASE, there is no error pulse.
- Address:
  - nxt increments per emitted full word.
  - At ADDR_BASE+FRAME_WORDS-1 it wraps to ADDR_BASE.
  - frame_wrap pulses the cycle after wr_ack of that last word.
- Handshake:
  - While wr_en=1 and wr_ack=0, wr_addr, wr_data and wr_be hold stable.
  - wr_ack is sampled only while wr_en=1; wr_ack with wr_en=0 is ignored.
  - Ack and a new word load in the same cycle keeps wr_en=1 and presents the new word next cycle (back-to-back, no bubble).
  - Ack without a new word clears wr_en.
- Back-pressure:
  - With count==7 and the slot busy, pix_ready=0 until the cycle wr_ack=1.
  - An sof pixel with count in 1..6 and the slot busy also stalls.
  - No pixel is ever dropped or duplicated.
- pix_valid=0 leaves all state unchanged except handshake completion.

Test Plan:
- Reset, then sof + pixels 0x00..0x07 with wr_ack tied 1 → one write: addr 0, data 64'h0706050403020100, be 8'hFF; wr_en high exactly 1 cycle, starting the edge after pixel 0x07.
- 16 pixels, wr_ack held 0 for 5 cycles after the first wr_en → pix_ready low on pixel 15 until ack; then second word at addr 1, data bytes 0x08..0x0F; wr_data stable throughout the stall.
- FRAME_WORDS=4, 32 pixels with ack=1 → addrs 0,1,2,3; frame_wrap pulses once after ack of addr 3; the next word goes to addr 0.
- sof after 3 pixels (0xA0,0xA1,0xA2) of word 5 → flush addr 5, data 64'h0000000000A2A1A0, be 8'h07, err_short one pulse; the following full word goes to addr 0 with the sof pixel in byte 0.
- Assert reset mid-stall (wr_en=1, count=4) → wr_en, count and addr clear immediately (asynchronously); after release, sof + 8 pixels writes addr 0 normally.
- Random pix_valid / wr_ack gaps over 3 frames of 64 words → scoreboard matches every byte, no loss, addresses monotonic with wrap.
